// File: rtl/uart_tx.sv
// UART transmitter: accepts a parallel word on a one-cycle enable and sends it
// as start bit, LSB-first payload and one or two stop bits at a fixed bit rate.
module uart_tx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_txd,
    output logic                    uart_tx_busy
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
    localparam int BW             = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] LAST_CYC  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    last_cyc;

    assign last_cyc = (cyc_q == LAST_CYC);

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latch).
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                cyc_d     = '0;
                bit_cnt_d = '0;
                if (uart_tx_en) begin
                    state_d = START;
                    shift_d = uart_tx_data;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (last_cyc) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            DATA: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        txd_d     = shift_d[0];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            STOP: begin
                // The bit counter is reused to count stop bits, so the cycle
                // counter never has to span more than one bit period.
                txd_d = 1'b1;
                if (last_cyc) begin
                    cyc_d = '0;
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
        // NOTE: the shift register is pure datapath, always reloaded on accept, so it needs no reset.
        shift_q <= shift_d;
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with one stop bit, one with two,
// both at 10 clock cycles per bit.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] data;
    logic       txd;
    logic       busy;
    logic       en2;
    logic [7:0] data2;
    logic       txd2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CLK_HZ      (100),
        .BIT_RATE    (10),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_tx_en  (en),
        .uart_tx_data(data),
        .uart_txd    (txd),
        .uart_tx_busy(busy)
    );

    uart_tx #(
        .CLK_HZ      (100),
        .BIT_RATE    (10),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (2)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .uart_tx_en  (en2),
        .uart_tx_data(data2),
        .uart_txd    (txd2),
        .uart_tx_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accepting edge; returns at the first idle cycle.
    task automatic capture(input int which, input int inj_cycle, input logic [7:0] inj_data,
                           output logic [11:0] bits, output int busy_cycles,
                           output int hi_run, output int done);
        int n;
        n           = 0;
        bits        = '0;
        busy_cycles = 0;
        hi_run      = 0;
        done        = 0;
        for (int c = 0; c < 300; c++) begin
            logic t;
            logic b;
            t = (which != 0) ? txd2 : txd;
            b = (which != 0) ? busy2 : busy;
            if (!b) begin
                done = 1;
                break;
            end
            busy_cycles++;
            hi_run = t ? hi_run + 1 : 0;
            if ((c % 10) == 6 && n < 12) begin
                bits[n] = t;
                n++;
            end
            if (c == inj_cycle) begin
                en   = 1'b1;
                data = inj_data;
            end else if (c == inj_cycle + 1) begin
                en = 1'b0;
            end
            tick();
        end
    endtask

    task automatic frame(input string tag, input int which, input int inj_cycle,
                         input logic [7:0] inj_data, input logic [11:0] exp_bits,
                         input int exp_busy, input int exp_hi);
        logic [11:0] bits;
        int          busy_cycles;
        int          hi_run;
        int          done;
        capture(which, inj_cycle, inj_data, bits, busy_cycles, hi_run, done);
        check({tag, " frame_end"}, done, 1);
        check({tag, " bits"}, bits, exp_bits);
        check({tag, " busy_len"}, busy_cycles, exp_busy);
        check({tag, " high_tail"}, hi_run, exp_hi);
        check({tag, " idle_txd"}, (which != 0) ? txd2 : txd, 1'b1);
    endtask

    initial begin
        int seen_busy;
        reset = 1'b1;
        en    = 1'b0;
        data  = 8'h00;
        en2   = 1'b0;
        data2 = 8'h00;
        tick();
        tick();
        check("reset txd/busy", {txd, busy}, 2'b10);
        check("reset txd2/busy2", {txd2, busy2}, 2'b10);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle txd/busy", {txd, busy}, 2'b10);
        end

        // Single pulse; data changed right after acceptance must not matter.
        en   = 1'b1;
        data = 8'hAB;
        tick();
        en   = 1'b0;
        data = 8'h00;
        check("ab latency", {txd, busy}, 2'b01);
        frame("ab", 0, 1000, 8'h00, 12'h356, 100, 20);

        repeat (3) tick();

        // Request during the frame is ignored.
        en   = 1'b1;
        data = 8'h5C;
        tick();
        en = 1'b0;
        frame("5c", 0, 30, 8'hFF, 12'h2B8, 100, 10);
        seen_busy = 0;
        repeat (30) begin
            tick();
            if (busy || !txd) seen_busy++;
        end
        check("5c no second frame", seen_busy, 0);

        // Enable held high: exactly one idle cycle between frames.
        en   = 1'b1;
        data = 8'hF0;
        tick();
        data = 8'h0F;
        check("f0 latency", {txd, busy}, 2'b01);
        frame("f0", 0, 1000, 8'h00, 12'h3E0, 100, 50);
        tick();
        check("b2b gap one cycle", {txd, busy}, 2'b01);
        en = 1'b0;
        frame("0f", 0, 1000, 8'h00, 12'h21E, 100, 10);

        // Reset in the middle of data bit 3, with a simultaneous request.
        en   = 1'b1;
        data = 8'h00;
        tick();
        en = 1'b0;
        repeat (43) tick();
        check("00 in data bit3", {txd, busy}, 2'b01);
        reset = 1'b1;
        en    = 1'b1;
        data  = 8'h55;
        tick();
        check("mid reset txd/busy", {txd, busy}, 2'b10);
        reset = 1'b0;
        tick();
        check("accept after reset", {txd, busy}, 2'b01);
        en = 1'b0;
        frame("55", 0, 1000, 8'h00, 12'h2AA, 100, 10);

        // Two stop bits.
        en2   = 1'b1;
        data2 = 8'h80;
        tick();
        en2 = 1'b0;
        check("s2 latency", {txd2, busy2}, 2'b01);
        frame("s2_80", 1, 1000, 8'h00, 12'h700, 110, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
